seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..16.
REQ-002 Parameter PARITY_EN, default 1: 1 appends an odd-parity bit to each frame; 0 omits it.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 areset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  payload offered by upstream.
REQ-006 in_data  input  DATA_W  payload; sampled only on acceptance.
REQ-007 in_ready  output  1  block can accept a payload this cycle.
REQ-008 out  output  1  serial line driven to the "101" sync detector.
REQ-009 out_frame  output  1  high while a frame bit (preamble, data or parity) is on out.
REQ-010 done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-011 Moore FSM with states IDLE, PRE1, PRE0, PRE2, DATA, PAR, GAP; out, out_frame and done SHALL be decoded from registered state and shift register only, with no combinational path from inputs.
REQ-012 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-013 Acceptance: in_valid=1 and in_ready=1 at a rising edge; at that edge in_data SHALL be latched into a DATA_W-bit shift register and the state SHALL become PRE1.
REQ-014 in_valid while not in IDLE SHALL be ignored; in_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-015 Preamble: PRE1 drives out=1, PRE0 drives out=0, PRE2 drives out=1; each state lasts one cycle, in that order.
REQ-016 DATA SHALL last exactly DATA_W cycles, with out = latched payload MSB first; the bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL NOT wrap within a frame.
REQ-017 After the last data bit: go to PAR if PARITY_EN=1, otherwise to GAP.
REQ-018 PAR SHALL last one cycle with out = XNOR-reduction of the latched payload, so the data plus parity bits contain an odd number of ones.
REQ-019 GAP SHALL last one cycle with out=0, out_frame=0 and done=1, then go to IDLE.
REQ-020 out_frame SHALL be 1 in PRE1, PRE0, PRE2, DATA and PAR, and 0 in IDLE and GAP.
REQ-021 In IDLE: out=0, out_frame=0, done=0.
REQ-022 Frame timing: for acceptance at edge k, the first preamble bit SHALL appear in the cycle after k; GAP SHALL occur 3+DATA_W+PARITY_EN cycles later; total busy time is 4+DATA_W+PARITY_EN cycles.
REQ-023 Back-to-back operation: at least one IDLE cycle separates frames, and the earliest next acceptance is at the end of the first IDLE cycle after GAP.
REQ-024 A payload of all zeros SHALL still produce the full preamble, DATA_W zero bits and parity bit 1.

Reset
REQ-025 While areset=1, independent of clk: state=IDLE, shift register and bit counter cleared, out=0, out_frame=0, done=0, in_ready=1.
REQ-026 areset asserted mid-frame SHALL abort the frame immediately, with no done pulse and no resumption; after release, the first acceptance SHALL start a fresh frame at PRE1.
REQ-027 in_valid=1 at the first rising edge after areset deasserts SHALL be accepted normally.

Verification
REQ-028 Reset check: assert areset with in_valid=1 and random in_data -> out=0, out_frame=0, done=0, in_ready=1 and no frame started.
REQ-029 Single frame, default parameters: in_data=8'hA5 accepted -> out sequence 1,0,1, 1,0,1,0,0,1,0,1, 1, then 0 with done=1; out_frame high for 12 cycles; in_ready low for 13 cycles.
REQ-030 Back-to-back frames: in_valid held high with 8'hFF then 8'h00 -> bits 1,0,1,11111111,1,gap,idle, then 1,0,1,00000000,1; exactly one IDLE cycle between the frames.
REQ-031 Busy-time stability: change in_data every cycle during a frame of 8'h3C -> transmitted data 00111100 and parity 1, unaffected by the changes.
REQ-032 Mid-frame abort: assert areset during the 4th data bit of 8'hC3 -> out=0 and in_ready=1 at once, no done pulse; a new 8'h01 frame then runs complete and correct.
REQ-033 Parameter variant DATA_W=4, PARITY_EN=0: in_data=4'hB -> 1,0,1,1,0,1,1, then the gap with done=1; busy time of 8 cycles.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-line bundle for seq_pattern_tx.
// master = upstream payload source, slave = the transmitter itself.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out;
  logic              out_frame;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out, out_frame, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out, out_frame, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: on acceptance it sends the "101" preamble,
// the latched payload MSB first, an optional odd-parity bit and a
// one-cycle gap that carries the done pulse. All outputs come straight
// from registers, so nothing on the line depends combinationally on inputs.
module seq_pattern_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic            clk,
  input  logic            areset,
  seq_pattern_tx_if.slave bus
);

  // Counter must hold the value DATA_W itself so it never wraps in a frame.
  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE1 = 3'd1,
    PRE0 = 3'd2,
    PRE2 = 3'd3,
    DATA = 3'd4,
    PAR  = 3'd5,
    GAP  = 3'd6
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_par;
  logic              r_out;
  logic              r_frame;
  logic              r_done;
  logic              r_ready;

  // Bit that makes payload plus parity carry an odd number of ones.
  function automatic logic odd_parity_bit(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

  // Frame sequencer; each output register is loaded with the value that
  // belongs to the state being entered, keeping outputs aligned with state.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_out   <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            // Parity is fixed at acceptance because the shift register
            // is consumed while the data bits go out.
            r_shift <= bus.in_data;
            r_par   <= odd_parity_bit(bus.in_data);
            r_cnt   <= '0;
            r_state <= PRE1;
            r_out   <= 1'b1;
            r_frame <= 1'b1;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_out   <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        PRE1: begin
          r_state <= PRE0;
          r_out   <= 1'b0;
        end
        PRE0: begin
          r_state <= PRE2;
          r_out   <= 1'b1;
        end
        PRE2: begin
          r_state <= DATA;
          r_out   <= r_shift[DATA_W-1];
          r_shift <= r_shift << 1;
          r_cnt   <= CNT_W'(1);
        end
        DATA: begin
          // r_cnt counts bits already placed on the line.
          if (r_cnt == LAST_CNT) begin
            if (PARITY_EN != 0) begin
              r_state <= PAR;
              r_out   <= r_par;
            end else begin
              r_state <= GAP;
              r_out   <= 1'b0;
              r_frame <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_out   <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        PAR: begin
          r_state <= GAP;
          r_out   <= 1'b0;
          r_frame <= 1'b0;
          r_done  <= 1'b1;
        end
        GAP: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_frame <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_shift <= '0;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_frame <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.out       = r_out;
  assign bus.out_frame = r_frame;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one default instance (8 bits, parity) and one
// 4-bit instance without parity. Frames come from a table of payloads with
// hand-computed line patterns; starting a frame pushes its expected
// {in_ready,out,out_frame,done} words into a per-instance queue, and every
// cycle the observed word is compared against the queue head (or IDLE).
module tb_seq_pattern_tx;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [15:0] bits;
    int          nbits;
    string       name;
  } frame_t;

  logic       clk = 1'b0;
  logic       areset;
  logic       tb_valid [2];
  logic [7:0] tb_data  [2];

  frame_t     tbl [10];
  logic [3:0] q    [2][$];
  int         pend [2][$];
  bit         was_idle [2];
  string      cur_name [2];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  seq_pattern_tx_if #(.DATA_W(8)) if_a ();
  seq_pattern_tx_if #(.DATA_W(4)) if_b ();

  seq_pattern_tx #(.DATA_W(8), .PARITY_EN(1)) u_dut_a (
    .clk    (clk),
    .areset (areset),
    .bus    (if_a)
  );

  seq_pattern_tx #(.DATA_W(4), .PARITY_EN(0)) u_dut_b (
    .clk    (clk),
    .areset (areset),
    .bus    (if_b)
  );

  assign if_a.in_valid = tb_valid[0];
  assign if_a.in_data  = tb_data[0];
  assign if_b.in_valid = tb_valid[1];
  assign if_b.in_data  = tb_data[1][3:0];

  wire [3:0] w_obs_a = {if_a.in_ready, if_a.out, if_a.out_frame, if_a.done};
  wire [3:0] w_obs_b = {if_b.in_ready, if_b.out, if_b.out_frame, if_b.done};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case the run wedges somewhere.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by t=%0t, want finish earlier", $time);
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got rdy/out/frm/done=%b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] act);
    logic [3:0] exp;
    was_idle[d] = (q[d].size() == 0);
    if (was_idle[d]) exp = 4'b1000;
    else             exp = q[d].pop_front();
    cmp($sformatf("dut%0d_%s", d, was_idle[d] ? "idle" : cur_name[d]), act, exp);
  endtask

  task automatic start_frame(input int d, input int idx);
    cur_name[d] = tbl[idx].name;
    for (int i = tbl[idx].nbits - 1; i >= 0; i--)
      q[d].push_back({1'b0, tbl[idx].bits[i], 1'b1, 1'b0});
    q[d].push_back(4'b0001);
    tb_valid[d] = 1'b1;
    tb_data[d]  = tbl[idx].data;
  endtask

  // One cycle: check both instances at the falling edge, then drive inputs
  // for the next rising edge. While busy, in_valid stays high and in_data
  // is scrambled to prove both are ignored.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check_dut(0, w_obs_a);
    check_dut(1, w_obs_b);
    for (int d = 0; d < 2; d++) begin
      if (was_idle[d] && pend[d].size() > 0) begin
        start_frame(d, pend[d].pop_front());
      end else if (was_idle[d]) begin
        tb_valid[d] = 1'b0;
        tb_data[d]  = 8'($urandom);
      end else begin
        tb_valid[d] = 1'b1;
        tb_data[d]  = 8'($urandom);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + pend[0].size() + pend[1].size()) != 0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL %s_timeout: got %0d cycles without draining, want under 400", tag, n);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    tbl[0] = '{0, 8'hA5, 16'b101_10100101_1, 12, "A5"};
    tbl[1] = '{0, 8'hFF, 16'b101_11111111_1, 12, "FF"};
    tbl[2] = '{0, 8'h00, 16'b101_00000000_1, 12, "00"};
    tbl[3] = '{0, 8'h3C, 16'b101_00111100_1, 12, "3C"};
    tbl[4] = '{0, 8'h80, 16'b101_10000000_0, 12, "80"};
    tbl[5] = '{0, 8'h7F, 16'b101_01111111_0, 12, "7F"};
    tbl[6] = '{1, 8'h0B, 16'b101_1011,        7, "w4_B"};
    tbl[7] = '{1, 8'h00, 16'b101_0000,        7, "w4_0"};
    tbl[8] = '{0, 8'hC3, 16'b101_11000011_1, 12, "C3"};
    tbl[9] = '{0, 8'h01, 16'b101_00000001_0, 12, "01"};

    // Reset held with in_valid high and random data: nothing may start.
    areset      = 1'b1;
    tb_valid[0] = 1'b1;
    tb_valid[1] = 1'b1;
    tb_data[0]  = 8'($urandom);
    tb_data[1]  = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc++;
      cmp("reset_a", w_obs_a, 4'b1000);
      cmp("reset_b", w_obs_b, 4'b1000);
    end
    areset      = 1'b0;
    tb_valid[0] = 1'b0;
    tb_valid[1] = 1'b0;

    // Table frames, queued back to back on each instance.
    for (int i = 0; i < 8; i++) pend[tbl[i].dut].push_back(i);
    drain("table");

    // Abort C3 during its 4th data bit, then restart with 01 right at release.
    pend[0].push_back(8);
    begin
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < 50 && !reached; c++) begin
        tick();
        if (q[0].size() == 6) reached = 1'b1;
      end
      checks++;
      if (!reached) begin
        failures++;
        $display("FAIL abort_reach: got no 4th data bit within 50 cycles, want it reached");
      end
    end
    #2;
    areset = 1'b1;
    #1;
    cmp("abort_now_a", w_obs_a, 4'b1000);
    cmp("abort_now_b", w_obs_b, 4'b1000);
    q[0].delete();
    tb_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    cmp("abort_hold_a", w_obs_a, 4'b1000);
    areset = 1'b0;
    start_frame(0, 9);
    drain("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
